stage6_micropipeline: RTL and testbench
=======================================

Name: stage6_micropipeline

Overview:
- Six-stage, two-phase (transition-signalled) bundled-data micropipeline for DATA_W-bit tokens, built as a clocked emulation of a Sutherland-style asynchronous pipeline.
- Upstream hands tokens in with req_in/ack_out; downstream takes them out with req_out/ack_in.
- Sits between two handshake domains as an elastic buffer that holds up to DEPTH tokens.

Parameters:
- DATA_W, 3, token width in bits.
- DEPTH, 6, number of stages; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  1  upstream request; each transition (either edge) offers one new token.
- ack_out  output  1  upstream acknowledge; each transition accepts one token.
- data_in  input  DATA_W  token offered with req_in.
- req_out  output  1  downstream request; each transition presents one new token.
- ack_in  input  1  downstream acknowledge; each transition consumes the presented token.
- data_out  output  DATA_W  token presented with req_out.

Behaviour:
- State per stage k (0..DEPTH-1): phase bit p[k] and data register d[k].
- Boundary aliases: p[-1]=req_in, d[-1]=data_in, p[DEPTH]=ack_in.
- Stage k is full when p[k] != p[k+1], and empty otherwise.
- Fire rule, evaluated every rising clk edge from pre-edge values for all stages in parallel:
  - fire_k = (p[k-1] != p[k]) && (p[k] == p[k+1]).
  - On fire: p[k] <= ~p[k] and d[k] <= d[k-1].
  - Otherwise hold.
- Outputs are direct register outputs with no combinational path from inputs:
  - ack_out = p[0]
  - req_out = p[DEPTH-1]
  - data_out = d[DEPTH-1]
- Upstream protocol:
  - Upstream may toggle req_in only when req_in == ack_out.
  - data_in must be stable from the req_in toggle until ack_out matches req_in.
  - A req_in toggle while req_in != ack_out is a protocol violation; behaviour is undefined, but there is no lockup after reset.
- Downstream protocol:
  - A token is pending when req_out != ack_in.
  - data_out is stable while pending.
  - Downstream toggles ack_in once per token.
- Latency:
  - Empty pipe: req_in toggle sampled at edge n → ack_out toggles at edge n, req_out toggles at edge n+DEPTH-1 (visible after DEPTH edges counting the sampling edge).
  - Each hop takes one clock.
- Throughput:
  - At most one token accepted per two clocks at ack_out (a stage must empty before refilling).
  - Capacity is exactly DEPTH tokens.
- Full pipe (all stages full): ack_out does not toggle until ack_in toggles. The freed slot then propagates back one stage per clock.
- Simultaneous events: a req_in toggle and an ack_in toggle on the same edge are both handled. Each stage's decision uses only pre-edge neighbour values.
- Reset (asynchronous, active-high):
  - All p[k]=0 and d[k]=0, so req_out=0, ack_out=0, data_out=0.
  - Reset mid-operation discards all tokens immediately.
  - After release, environment handshake levels must be req_in=0 and ack_in=0, otherwise the mismatch is treated as a new token or acknowledge.
- No internal counters are required for the core function.

Optional Feature:
- Macro STAGE6_OCCUPANCY_EN.
- When defined:
  - Adds output occupancy, width $clog2(DEPTH+1), registered.
  - Value = number of full stages (popcount of p[k]^p[k+1]), updated on the same edge as the phase bits.
  - Reset value 0; maximum DEPTH.
- When undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → req_out=0, ack_out=0, data_out=0 immediately, with no clk edge needed.
- Single token: req_in 0→1 with data_in=3, ack_in=0 → ack_out=1 after first edge; req_out=1 with data_out=3 after 6 edges.
- Fill/stall: ack_in held 0; send tokens 1..6, toggling req_in each time ack_out==req_in → all six acknowledged. A 7th token (data 7) stays unacknowledged; ack_out != req_in persists for 20 clocks.
- Drain order: from the full state, toggle ack_in whenever req_out != ack_in → data_out sequence 1,2,3,4,5,6, then 7 arrives. With STAGE6_OCCUPANCY_EN, occupancy goes 6→…→0.
- Streaming: ack_in toggled on every req_out change, 16 tokens 0..7 repeating → output order preserved, no loss or duplication, one token per 2 clocks sustained.
- Reset mid-stream: 3 tokens in flight, pulse rst → outputs 0; after release with req_in=ack_in=0 the next token (5) passes normally with 6-edge latency.

Source files
------------

// File: rtl/stage6_micropipeline.sv
// Clocked two-phase bundled-data micropipeline (Sutherland-style), DEPTH stages deep.
// Define STAGE6_OCCUPANCY_EN to add a registered count of full stages on port occupancy.
module stage6_micropipeline #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  output logic              ack_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              req_out,
  input  logic              ack_in,
  output logic [DATA_W-1:0] data_out
`ifdef STAGE6_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]  p;
  logic [DEPTH-1:0]  p_nxt;
  logic [DEPTH-1:0]  fire;
  logic [DEPTH+1:0]  pe;
  logic [DATA_W-1:0] d     [DEPTH];
  logic [DATA_W-1:0] d_src [DEPTH];

  // pe[0] is req_in, pe[k+1] is stage k, pe[DEPTH+1] is ack_in; every stage
  // decides from pre-edge neighbour phases only.
  always_comb begin
    pe       = {ack_in, p, req_in};
    d_src[0] = data_in;
    for (int k = 1; k < DEPTH; k++) begin
      d_src[k] = d[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      fire[k] = (pe[k] != pe[k+1]) && (pe[k+1] == pe[k+2]);
    end
    p_nxt = p ^ fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= p_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (fire[k]) begin
          d[k] <= d_src[k];
        end
      end
    end
  end

  assign ack_out  = p[0];
  assign req_out  = p[DEPTH-1];
  assign data_out = d[DEPTH-1];

`ifdef STAGE6_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH:0]   pn_ext;
  logic [DEPTH-1:0] full_nxt;
  logic [OCC_W-1:0] occ_nxt;

  // Counted from post-edge phases so the count moves on the same edge as p.
  always_comb begin
    pn_ext   = {ack_in, p_nxt};
    full_nxt = pn_ext[DEPTH-1:0] ^ pn_ext[DEPTH:1];
    occ_nxt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OCC_W'(full_nxt[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_stage6_micropipeline.sv
// Scoreboard bench for stage6_micropipeline: reset, latency, fill/stall, drain, streaming, mid-stream reset.
module tb_stage6_micropipeline;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 6;
  localparam int OCC_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_in = 1'b0;
  logic              ack_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ack_out;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
`ifdef STAGE6_OCCUPANCY_EN
  logic [OCC_W-1:0]  occupancy;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];

  stage6_micropipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .ack_out(ack_out),
    .data_in(data_in),
    .req_out(req_out),
    .ack_in(ack_in),
    .data_out(data_out)
`ifdef STAGE6_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the upstream handshake to be idle, then offers v.
  task automatic offer(input logic [DATA_W-1:0] v, output bit ok);
    int t = 0;
    while (ack_out !== req_in && t < 60) begin
      step();
      t++;
    end
    ok = (ack_out === req_in);
    if (ok) begin
      data_in = v;
      req_in  = ~req_in;
      exp_q.push_back(v);
    end
  endtask

  task automatic test_reset;
    step(2);
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL rst_req_out got %b want 0", req_out); end
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("FAIL rst_ack_out got %b want 0", ack_out); end
    vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rst_data_out got %0d want 0", data_out); end
    @(negedge clk);
    rst = 1'b0;
    step(1);
    data_in = 3'd6;
    req_in  = 1'b1;
    step(6);
    vectors++; if (req_out !== 1'b1 || data_out !== 3'd6) begin
      miscompares++; $display("FAIL pre_async_rst got req_out=%b data_out=%0d want 1/6", req_out, data_out);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL async_rst_req_out got %b want 0", req_out); end
    vectors++; if (ack_out !== 1'b0) begin miscompares++; $display("FAIL async_rst_ack_out got %b want 0", ack_out); end
    vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL async_rst_data_out got %0d want 0", data_out); end
    req_in  = 1'b0;
    ack_in  = 1'b0;
    data_in = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1);
`ifdef STAGE6_OCCUPANCY_EN
    vectors++; if (occupancy !== '0) begin miscompares++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
`endif
  endtask

  task automatic test_single;
    data_in = 3'd3;
    req_in  = 1'b1;
    step(1);
    vectors++; if (ack_out !== 1'b1) begin miscompares++; $display("FAIL single_ack got %b want 1", ack_out); end
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL single_req_early got %b want 0", req_out); end
    step(4);
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL single_req_edge5 got %b want 0", req_out); end
    step(1);
    vectors++; if (req_out !== 1'b1) begin miscompares++; $display("FAIL single_req_edge6 got %b want 1", req_out); end
    vectors++; if (data_out !== 3'd3) begin miscompares++; $display("FAIL single_data got %0d want 3", data_out); end
    ack_in = 1'b1;
    step(2);
    vectors++; if (req_out !== ack_in) begin miscompares++; $display("FAIL single_idle got req_out=%b want %b", req_out, ack_in); end
  endtask

  task automatic test_fill_stall;
    bit ok;
    bit stalled = 1'b1;
    for (int v = 1; v <= 7; v++) begin
      offer(3'(v), ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL fill_offer_%0d got timeout want accepted", v); end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_out === req_in) stalled = 1'b0;
    end
    vectors++; if (stalled !== 1'b1) begin miscompares++; $display("FAIL fill_stall_7th got accepted want held"); end
    vectors++; if (req_out === ack_in) begin miscompares++; $display("FAIL fill_pending got idle want pending"); end
    vectors++; if (data_out !== 3'd1) begin miscompares++; $display("FAIL fill_head got %0d want 1", data_out); end
`ifdef STAGE6_OCCUPANCY_EN
    vectors++; if (occupancy !== OCC_W'(DEPTH)) begin miscompares++; $display("FAIL fill_occupancy got %0d want %0d", occupancy, DEPTH); end
`endif
  endtask

  task automatic test_drain;
    int n = 0;
    int t = 0;
    logic [DATA_W-1:0] e;
    while (exp_q.size() > 0 && t < 200) begin
      if (req_out !== ack_in) begin
        e = exp_q.pop_front();
        vectors++; if (data_out !== e) begin miscompares++; $display("FAIL drain_data_%0d got %0d want %0d", n, data_out, e); end
        ack_in = ~ack_in;
        n++;
      end
      step();
      t++;
    end
    vectors++; if (n !== 7) begin miscompares++; $display("FAIL drain_count got %0d want 7", n); end
    step(3);
    vectors++; if (ack_out !== req_in) begin miscompares++; $display("FAIL drain_upstream_idle got %b want %b", ack_out, req_in); end
    vectors++; if (req_out !== ack_in) begin miscompares++; $display("FAIL drain_empty got req_out=%b want %b", req_out, ack_in); end
`ifdef STAGE6_OCCUPANCY_EN
    vectors++; if (occupancy !== '0) begin miscompares++; $display("FAIL drain_occupancy got %0d want 0", occupancy); end
`endif
  endtask

  task automatic test_streaming;
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = 0;
    int t = 0;
    logic [DATA_W-1:0] e;
    while (got < 16 && t < 400) begin
      if (req_out !== ack_in) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; $display("FAIL stream_extra got %0d want none", data_out);
        end else begin
          e = exp_q.pop_front();
          vectors++; if (data_out !== e) begin miscompares++; $display("FAIL stream_data_%0d got %0d want %0d", got, data_out, e); end
        end
        if (got == 0) first = cyc;
        last = cyc;
        got++;
        ack_in = ~ack_in;
      end
      if (sent < 16 && ack_out === req_in) begin
        data_in = 3'(sent % 8);
        req_in  = ~req_in;
        exp_q.push_back(3'(sent % 8));
        sent++;
      end
      step();
      t++;
    end
    vectors++; if (got !== 16) begin miscompares++; $display("FAIL stream_count got %0d want 16", got); end
    vectors++; if (last - first !== 30) begin miscompares++; $display("FAIL stream_rate got %0d cycles want 30", last - first); end
    step(4);
    vectors++; if (req_out !== ack_in || exp_q.size() !== 0) begin
      miscompares++; $display("FAIL stream_leftover got pending=%b queued=%0d want 0/0", req_out ^ ack_in, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream;
    bit ok;
    for (int v = 1; v <= 3; v++) begin
      offer(3'(v), ok);
    end
    step(4);
    #3;
    rst = 1'b1;
    #1;
    vectors++; if (req_out !== 1'b0 || ack_out !== 1'b0 || data_out !== '0) begin
      miscompares++; $display("FAIL mid_rst got req_out=%b ack_out=%b data_out=%0d want 0/0/0", req_out, ack_out, data_out);
    end
    req_in  = 1'b0;
    ack_in  = 1'b0;
    data_in = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1);
    data_in = 3'd5;
    req_in  = 1'b1;
    step(1);
    vectors++; if (ack_out !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ack got %b want 1", ack_out); end
    step(4);
    vectors++; if (req_out !== 1'b0) begin miscompares++; $display("FAIL mid_rst_req_edge5 got %b want 0", req_out); end
    step(1);
    vectors++; if (req_out !== 1'b1 || data_out !== 3'd5) begin
      miscompares++; $display("FAIL mid_rst_token got req_out=%b data_out=%0d want 1/5", req_out, data_out);
    end
    ack_in = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill_stall;
    test_drain;
    test_streaming;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
